// File: rtl/brg_xcel_csr_slave.sv
// CSR slave front end for a BRG accelerator tile: argument bank, go/busy/done FSM, 1-cycle responses.
// Optional BRG_XCEL_CSR_RD_CLEAR_EN: STATUS loads clear done/err after returning them.
module brg_xcel_csr_slave #(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned num_csr_p    = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   in_v_i,
    input  logic [addr_width_p-1:0]                in_addr_i,
    input  logic [data_width_p-1:0]                in_data_i,
    input  logic [data_width_p/8-1:0]              in_mask_i,
    input  logic                                   in_we_i,
    output logic                                   in_yumi_o,
    output logic                                   returning_v_o,
    output logic [data_width_p-1:0]                returning_data_o,
    output logic                                   xcel_go_o,
    output logic                                   xcel_busy_o,
    input  logic                                   xcel_done_i,
    input  logic [data_width_p-1:0]                xcel_result_i,
    output logic [(num_csr_p-3)*data_width_p-1:0]  args_o
);

    localparam int unsigned lg_csr_lp  = $clog2(num_csr_p);
    localparam int unsigned num_arg_lp = num_csr_p - 3;
    localparam int unsigned num_byte_lp = data_width_p / 8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                  state_q, state_d;
    logic                    go_q, go_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [data_width_p-1:0] result_q, result_d;
    logic [data_width_p-1:0] args_q [num_arg_lp];
    logic [data_width_p-1:0] args_d [num_arg_lp];
    logic                    resp_v_q;
    logic [data_width_p-1:0] resp_data_q, rd_data;

    logic [lg_csr_lp-1:0] idx;
    logic in_range, accept, is_load, is_store;
    logic sel_cmd, sel_status, sel_result, sel_arg;
    logic done_clr, err_clr;

    assign in_yumi_o  = in_v_i & reset_n_i;
    assign accept     = in_yumi_o;
    assign idx        = in_addr_i[lg_csr_lp-1:0];
    assign in_range   = ~|in_addr_i[addr_width_p-1:lg_csr_lp];
    assign is_load    = accept & ~in_we_i & in_range;
    assign is_store   = accept & in_we_i & in_range;
    assign sel_cmd    = (idx == lg_csr_lp'(0));
    assign sel_status = (idx == lg_csr_lp'(1));
    assign sel_result = (idx == lg_csr_lp'(2));
    assign sel_arg    = (idx >= lg_csr_lp'(3));

    // Read mux always sees pre-update state.
    always_comb begin
        rd_data = '0;
        if (is_load) begin
            if (sel_cmd) begin
                rd_data[0] = (state_q == StBusy);
            end else if (sel_status) begin
                rd_data[2:0] = {err_q, done_q, state_q == StBusy};
            end else if (sel_result) begin
                rd_data = result_q;
            end else begin
                for (int k = 3; k < int'(num_csr_p); k++) begin
                    if (idx == lg_csr_lp'(k)) rd_data = args_q[k-3];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        go_d     = 1'b0;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
        args_d   = args_q;
        done_clr = 1'b0;
        err_clr  = 1'b0;

        if (is_store && sel_status && in_mask_i[0]) begin
            done_clr = in_data_i[1];
            err_clr  = in_data_i[2];
        end
`ifdef BRG_XCEL_CSR_RD_CLEAR_EN
        if (is_load && sel_status) begin
            done_clr = 1'b1;
            err_clr  = 1'b1;
        end
`endif
        if (done_clr) done_d = 1'b0;
        if (err_clr)  err_d  = 1'b0;

        // Sets are applied after clears so a same-cycle set wins.
        unique case (state_q)
            StIdle: begin
                if (is_store && sel_cmd && |in_mask_i) begin
                    state_d = StBusy;
                    go_d    = 1'b1;
                end
            end
            StBusy: begin
                if (xcel_done_i) begin
                    state_d  = StIdle;
                    result_d = xcel_result_i;
                    done_d   = 1'b1;
                end
                if (is_store && (sel_cmd || sel_arg)) err_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (is_store && sel_arg && state_q == StIdle) begin
            for (int k = 3; k < int'(num_csr_p); k++) begin
                if (idx == lg_csr_lp'(k)) begin
                    for (int b = 0; b < int'(num_byte_lp); b++) begin
                        if (in_mask_i[b]) args_d[k-3][8*b +: 8] = in_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            go_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            args_q      <= '{default: '0};
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            args_q      <= args_d;
            resp_v_q    <= accept;
            resp_data_q <= rd_data;
        end
    end

    assign returning_v_o    = resp_v_q;
    assign returning_data_o = resp_data_q;
    assign xcel_go_o        = go_q;
    assign xcel_busy_o      = (state_q == StBusy);

    for (genvar k = 0; k < int'(num_arg_lp); k++) begin : g_args
        assign args_o[k*data_width_p +: data_width_p] = args_q[k];
    end

endmodule

// File: tb/tb_brg_xcel_csr_slave.sv
// Scoreboard bench for brg_xcel_csr_slave: requests push expected responses, a negedge monitor checks them.
module tb_brg_xcel_csr_slave;

    localparam int NumCsr = 8;
`ifdef BRG_XCEL_CSR_RD_CLEAR_EN
    localparam logic [31:0] Status2nd = 32'h0;
`else
    localparam logic [31:0] Status2nd = 32'h2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_v, in_we, in_yumi, ret_v, go, busy, xdone;
    logic [31:0] in_addr, in_data, ret_data, xresult;
    logic [3:0]  in_mask;
    logic [(NumCsr-3)*32-1:0] args;

    typedef struct {
        int          due;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   nerr = 0;
    int   nchk = 0;

    brg_xcel_csr_slave #(
        .addr_width_p(32),
        .data_width_p(32),
        .num_csr_p   (NumCsr)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .in_v_i          (in_v),
        .in_addr_i       (in_addr),
        .in_data_i       (in_data),
        .in_mask_i       (in_mask),
        .in_we_i         (in_we),
        .in_yumi_o       (in_yumi),
        .returning_v_o   (ret_v),
        .returning_data_o(ret_data),
        .xcel_go_o       (go),
        .xcel_busy_o     (busy),
        .xcel_done_i     (xdone),
        .xcel_result_i   (xresult),
        .args_o          (args)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response must land exactly in its due cycle with the expected data.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                nchk++;
                if (!ret_v || ret_data !== e.data) begin
                    nerr++;
                    $display("FAIL resp %s: got v=%0b data=%h, want v=1 data=%h",
                             e.name, ret_v, ret_data, e.data);
                end
            end else if (ret_v) begin
                nchk++;
                nerr++;
                $display("FAIL resp unexpected: got v=1 data=%h, want v=0", ret_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [31:0] exp, input string name);
        in_v    = 1'b1;
        in_we   = we;
        in_addr = addr;
        in_data = data;
        in_mask = mask;
        sb.push_back('{cyc + 1, we ? 32'h0 : exp, name});
        #1;
        chk({"yumi ", name}, {63'h0, in_yumi}, 64'h1);
        @(posedge clk);
        #1;
        in_v  = 1'b0;
        in_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        in_v = 1'b1; in_we = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
        xdone = 1'b0; xresult = '0;
        #2;
        chk("yumi in reset", {63'h0, in_yumi}, 64'h0);
        tick();
        tick();
        chk("outs in reset", {59'h0, ret_v, go, busy, |ret_data, |args}, 64'h0);
        in_v = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("outs after reset", {60'h0, ret_v, go, busy, |args}, 64'h0);

        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h0, "status after reset");
        req(1'b1, 32'd3, 32'hDEADBEEF, 4'b0101, 32'h0, "st arg3 masked");
        req(1'b0, 32'd3, 32'h0, 4'h0, 32'h00AD00EF, "ld arg3 masked");
        chk("args_o arg3", {32'h0, args[31:0]}, 64'h00AD00EF);

        // Launch, then finish three cycles later with a coincident STATUS load.
        req(1'b1, 32'd0, 32'h1, 4'hF, 32'h0, "st cmd launch");
        chk("go+busy after launch", {62'h0, go, busy}, 64'h3);
        tick();
        chk("go one cycle", {62'h0, go, busy}, 64'h1);
        req(1'b0, 32'd0, 32'h0, 4'h0, 32'h1, "ld cmd busy");
        xdone = 1'b1; xresult = 32'h1234;
        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h1, "ld status on done");
        xdone = 1'b0; xresult = 32'h0;
        chk("busy falls", {62'h0, go, busy}, 64'h0);
        req(1'b0, 32'd2, 32'h0, 4'h0, 32'h1234, "ld result");
        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h2, "ld status done");
        req(1'b0, 32'd1, 32'h0, 4'h0, Status2nd, "ld status again");

        // Clear done, relaunch, then illegal stores while busy.
        req(1'b1, 32'd1, 32'h2, 4'h1, 32'h0, "w1c done");
        req(1'b1, 32'd0, 32'h1, 4'hF, 32'h0, "st cmd relaunch");
        chk("go relaunch", {63'h0, go}, 64'h1);
        req(1'b1, 32'd0, 32'h1, 4'hF, 32'h0, "st cmd while busy");
        chk("no go while busy", {62'h0, go, busy}, 64'h1);
        req(1'b1, 32'd4, 32'h55555555, 4'hF, 32'h0, "st arg4 while busy");
        req(1'b0, 32'd4, 32'h0, 4'h0, 32'h0, "ld arg4 unchanged");
        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h5, "ld status err");
        req(1'b1, 32'd1, 32'h6, 4'h1, 32'h0, "w1c err+done");
        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h1, "ld status busy only");

        xdone = 1'b1; xresult = 32'hCAFE;
        tick();
        xdone = 1'b0; xresult = 32'h0;
        chk("idle after done", {63'h0, busy}, 64'h0);

        req(1'b0, NumCsr + 3, 32'h0, 4'h0, 32'h0, "ld out of range");
        req(1'b1, NumCsr + 3, 32'hFFFFFFFF, 4'hF, 32'h0, "st out of range");
        req(1'b1, 32'd2, 32'h0, 4'hF, 32'h0, "st result ro");
        req(1'b1, 32'd4, 32'h11223344, 4'hF, 32'h0, "st arg4");
        req(1'b0, 32'd3, 32'h0, 4'h0, 32'h00AD00EF, "b2b ld arg3");
        req(1'b0, 32'd4, 32'h0, 4'h0, 32'h11223344, "b2b ld arg4");
        chk("args_o arg4", {32'h0, args[63:32]}, 64'h11223344);
        req(1'b0, 32'd2, 32'h0, 4'h0, 32'hCAFE, "ld result kept");

        // done pulse in IDLE must be ignored.
        req(1'b1, 32'd1, 32'h6, 4'h1, 32'h0, "w1c before idle done");
        xdone = 1'b1; xresult = 32'h9999;
        tick();
        xdone = 1'b0; xresult = 32'h0;
        req(1'b0, 32'd2, 32'h0, 4'h0, 32'hCAFE, "ld result idle done");
        req(1'b0, 32'd1, 32'h0, 4'h0, 32'h0, "ld status idle done");

        // Asynchronous reset mid-operation.
        req(1'b1, 32'd0, 32'h1, 4'hF, 32'h0, "st cmd before reset");
        tick();
        reset_n = 1'b0;
        #1;
        chk("reset clears", {61'h0, ret_v, go, busy}, 64'h0);
        chk("reset clears args", {63'h0, |args}, 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("scoreboard drained", 64'(sb.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
